// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared definitions for the ID/EX flush and stall controller.
package hazard_flush_ctrl_pkg;

  // Control bundle width and field positions (MSB first).
  localparam int unsigned CTRL_W     = 10;
  localparam int unsigned ALUSRC     = 9;
  localparam int unsigned ALUFUNC_HI = 8;
  localparam int unsigned ALUFUNC_LO = 5;
  localparam int unsigned REGDEST    = 4;
  localparam int unsigned READDMEM   = 3;
  localparam int unsigned WRITEDMEM  = 2;
  localparam int unsigned REGWRITE   = 1;
  localparam int unsigned MEMTOREG   = 0;

  // A bubble: every control bit cleared, so EX does nothing observable.
  localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

  typedef enum logic {
    IDLE,
    FLUSH
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count events, sticking at the maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// ID/EX control register with branch-flush and load-use bubble insertion.
module hazard_flush_ctrl #(
  parameter int unsigned CTRL_W       = hazard_flush_ctrl_pkg::CTRL_W,
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_readdmem,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              branch_taken,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              flush_active,
  output logic [CNT_W-1:0]  stall_events,
  output logic [CNT_W-1:0]  flush_events
);

  import hazard_flush_ctrl_pkg::*;

  // The branch cycle itself is the first bubble, so the counter covers the rest.
  localparam logic [3:0] Reload = 4'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;
  logic       in_flush;
  logic       bubble;
  logic       stall_inc;

  // Hazard detection and the combinational pipeline strobes.
  always_comb begin
    in_flush   = (state_q == FLUSH);
    load_use   = ex_readdmem && (ex_rd != '0) &&
                 ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    bubble     = branch_taken || in_flush || load_use;
    // A redirect must never be frozen by a stall.
    pc_write   = !load_use || branch_taken || in_flush;
    ifid_write = pc_write;
    ifid_flush = branch_taken || in_flush;
    stall_inc  = load_use && !branch_taken && !in_flush;
  end

  // Next-state and bubble down-counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (branch_taken && (FLUSH_CYCLES > 1)) begin
          state_d = FLUSH;
          cnt_d   = Reload;
        end
      end
      FLUSH: begin
        if (branch_taken) begin
          cnt_d = Reload;
        end else if (cnt_q == 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter, registered flush flag and the ID/EX control register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      flush_active <= 1'b0;
      ex_ctrl      <= CTRL_W'(NOP_CTRL);
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_active <= (state_d == FLUSH);
      ex_ctrl      <= bubble ? CTRL_W'(NOP_CTRL) : id_ctrl;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_inc),
    .count(stall_events)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (branch_taken),
    .count(flush_events)
  );

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench for hazard_flush_ctrl; expectations are queued by the driver
// and checked by an independent monitor just before each rising edge.
module tb_hazard_flush_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] id_ctrl;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rt, ex_readdmem, branch_taken;
  logic [9:0] ex_ctrl;
  logic       pc_write, ifid_write, ifid_flush, flush_active;
  logic [3:0] stall_events, flush_events;

  always #5 clk = ~clk;

  hazard_flush_ctrl #(
    .CTRL_W      (10),
    .REG_AW      (5),
    .FLUSH_CYCLES(3),
    .CNT_W       (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_ctrl     (id_ctrl),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_readdmem (ex_readdmem),
    .ex_rd       (ex_rd),
    .branch_taken(branch_taken),
    .ex_ctrl     (ex_ctrl),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .flush_active(flush_active),
    .stall_events(stall_events),
    .flush_events(flush_events)
  );

  typedef struct {
    logic       chk;
    logic [9:0] e_ctrl;
    logic       e_pc;
    logic       e_ifw;
    logic       e_fl;
    logic       e_fa;
    logic [3:0] e_s;
    logic [3:0] e_f;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic void cmp(string nm, string fld, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req);
    end
  endfunction

  // Apply one cycle of inputs on the falling edge and queue what must be seen.
  task automatic cyc(input string nm, input logic r, input logic [9:0] id,
                     input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                     input logic rm, input logic [4:0] xrd, input logic br,
                     input logic [9:0] e_ctrl, input logic e_pc, input logic e_fl,
                     input logic e_fa, input logic [3:0] e_s, input logic [3:0] e_f,
                     input logic chk = 1'b1);
    exp_t e;
    @(negedge clk);
    rst          = r;
    id_ctrl      = id;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = ur;
    ex_readdmem  = rm;
    ex_rd        = xrd;
    branch_taken = br;
    e.chk    = chk;
    e.e_ctrl = e_ctrl;
    e.e_pc   = e_pc;
    e.e_ifw  = e_pc;
    e.e_fl   = e_fl;
    e.e_fa   = e_fa;
    e.e_s    = e_s;
    e.e_f    = e_f;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // No-hazard cycle with default register operands.
  task automatic plain(input string nm, input logic [9:0] id, input logic br,
                       input logic [9:0] e_ctrl, input logic e_fl, input logic e_fa,
                       input logic [3:0] e_s, input logic [3:0] e_f);
    cyc(nm, 1'b0, id, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, br, e_ctrl, 1'b1, e_fl, e_fa, e_s, e_f);
  endtask

  // Monitor: sample 1 time unit before each rising edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.chk) begin
          cmp(nm, "ex_ctrl", 32'(ex_ctrl), 32'(e.e_ctrl));
          cmp(nm, "pc_write", 32'(pc_write), 32'(e.e_pc));
          cmp(nm, "ifid_write", 32'(ifid_write), 32'(e.e_ifw));
          cmp(nm, "ifid_flush", 32'(ifid_flush), 32'(e.e_fl));
          cmp(nm, "flush_active", 32'(flush_active), 32'(e.e_fa));
          cmp(nm, "stall_events", 32'(stall_events), 32'(e.e_s));
          cmp(nm, "flush_events", 32'(flush_events), 32'(e.e_f));
        end
      end
    end
  end

  initial begin
    int s;
    // Reset with all-ones control on the input.
    cyc("rst0", 1, 10'h3FF, 1, 2, 1, 0, 0, 0, 10'h000, 1, 0, 0, 0, 0, 1'b0);
    cyc("rst1", 1, 10'h3FF, 1, 2, 1, 0, 0, 0, 10'h000, 1, 0, 0, 0, 0);
    plain("rel",    10'h3FF, 0, 10'h000, 0, 0, 0, 0);
    // Pass-through, one-cycle latency.
    plain("pass0",  10'h001, 0, 10'h3FF, 0, 0, 0, 0);
    plain("pass1",  10'h155, 0, 10'h001, 0, 0, 0, 0);
    plain("pass2",  10'h2AA, 0, 10'h155, 0, 0, 0, 0);
    // Load-use on rs, then the bubble.
    cyc("lu_rs",     0, 10'h3C3, 5, 2, 1, 1, 5, 0, 10'h2AA, 0, 0, 0, 0, 0);
    plain("lu_bub", 10'h0F0, 0, 10'h000, 0, 0, 1, 0);
    // Register 0 never stalls; unused rt never stalls; used rt does.
    cyc("r0",        0, 10'h111, 0, 0, 1, 1, 0, 0, 10'h0F0, 1, 0, 0, 1, 0);
    cyc("rt_unused", 0, 10'h222, 1, 5, 0, 1, 5, 0, 10'h111, 1, 0, 0, 1, 0);
    cyc("lu_rt",     0, 10'h333, 1, 5, 1, 1, 5, 0, 10'h222, 0, 0, 0, 1, 0);
    plain("lu_rt_bub", 10'h044, 0, 10'h000, 0, 0, 2, 0);
    // Isolated branch: three bubbles, flush_active for two cycles.
    plain("br",     10'h155, 1, 10'h044, 1, 0, 2, 0);
    plain("fl1",    10'h155, 0, 10'h000, 1, 1, 2, 1);
    plain("fl2",    10'h155, 0, 10'h000, 1, 1, 2, 1);
    plain("fl3",    10'h155, 0, 10'h000, 0, 0, 2, 1);
    plain("fl_end", 10'h2AA, 0, 10'h155, 0, 0, 2, 1);
    // Re-branch during flush coinciding with load-use: no stall counted.
    plain("br2",    10'h0AA, 1, 10'h2AA, 1, 0, 2, 1);
    cyc("rebr_lu",   0, 10'h1FF, 5, 2, 1, 1, 5, 1, 10'h000, 1, 1, 1, 2, 2);
    cyc("fl_lu",     0, 10'h1FF, 5, 2, 1, 1, 5, 0, 10'h000, 1, 1, 1, 2, 3);
    plain("fl_b",     10'h123, 0, 10'h000, 1, 1, 2, 3);
    plain("fl_b_end", 10'h123, 0, 10'h000, 0, 0, 2, 3);
    plain("post",     10'h123, 0, 10'h123, 0, 0, 2, 3);
    // Twenty forced load-use cycles: counter must stick at 4'hF.
    for (int k = 0; k < 20; k++) begin
      s = (2 + k > 15) ? 15 : 2 + k;
      cyc($sformatf("sat%0d", k), 0, 10'h3FF, 5, 2, 1, 1, 5, 0,
          (k == 0) ? 10'h123 : 10'h000, 0, 0, 0, 4'(s), 3);
    end
    plain("sat_end",  10'h2AA, 0, 10'h000, 0, 0, 15, 3);
    plain("sat_hold", 10'h2AA, 0, 10'h2AA, 0, 0, 15, 3);
    // Reset mid-flush abandons the remaining bubbles.
    plain("br_rst",   10'h3FF, 1, 10'h2AA, 1, 0, 15, 3);
    cyc("rst_mid",   1, 10'h3FF, 1, 2, 1, 0, 0, 0, 10'h000, 1, 1, 1, 15, 4);
    plain("rst_rel",   10'h3FF, 0, 10'h000, 0, 0, 0, 0);
    plain("rst_after", 10'h3FF, 0, 10'h3FF, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #6;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
Parametrised successor to the ID-stage flush gating. It owns the ID/EX control register and inserts bubbles (all control bits zero) for two reasons: a taken branch, which triggers a configurable multi-cycle flush, and a detected load-use hazard, which triggers a one-cycle stall. It sits between the decoder/control unit and the EX stage. It drives the PC and IF/ID write-enable and flush strobes, and keeps saturating performance counters for flushes and stalls.

Parameters:
CTRL_W, 10, width of the control bundle (alusrc, alufunc[3:0], regdest, readdmem, writedmem, regwrite, memtoreg)
REG_AW, 5, register-address width
FLUSH_CYCLES, 2, bubbles injected per taken branch, including the branch cycle; legal range 1..15
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock
rst  in  1  reset
id_ctrl  in  CTRL_W  decoded control bundle of the instruction in ID
id_rs  in  REG_AW  source register 1 of the ID instruction
id_rt  in  REG_AW  source register 2 of the ID instruction
id_uses_rt  in  1  ID instruction reads rt
ex_readdmem  in  1  readdmem bit of the instruction currently in EX (fed back from ex_ctrl)
ex_rd  in  REG_AW  destination register of the instruction in EX
branch_taken  in  1  branch resolved taken this cycle
ex_ctrl  out  CTRL_W  registered ID/EX control bundle
pc_write  out  1  PC update enable (combinational)
ifid_write  out  1  IF/ID register write enable (combinational)
ifid_flush  out  1  clear the IF/ID register (combinational)
flush_active  out  1  high while in FLUSH state (registered)
stall_events  out  CNT_W  count of load-use stalls
flush_events  out  CNT_W  count of taken-branch flushes

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high (rst). It is sampled only on the rising edge of clk.
- Reset values: ex_ctrl=0, state=IDLE, cnt=0, flush_active=0, stall_events=0, flush_events=0. A reset mid-flush abandons the remaining bubbles.
- Hazard term: load_use = ex_readdmem & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)). Register 0 never causes a stall.
- Bubble term: bubble = branch_taken | (state == FLUSH) | load_use.
- Every cycle: ex_ctrl <= bubble ? 0 : id_ctrl. Latency from id_ctrl to ex_ctrl is 1 cycle.
- States: IDLE and FLUSH, with a down-counter cnt of 4 bits.
  - IDLE, branch_taken, FLUSH_CYCLES > 1: go to FLUSH with cnt <= FLUSH_CYCLES-1.
  - IDLE, branch_taken, FLUSH_CYCLES == 1: stay in IDLE.
  - FLUSH: cnt decrements each cycle; go to IDLE on the cycle where cnt == 1.
  - FLUSH, branch_taken: restart with cnt <= FLUSH_CYCLES-1. This increments flush_events again.
- Total consecutive bubbles after an isolated branch equals FLUSH_CYCLES.
- Priority: branch_taken or FLUSH overrides load_use.
  - pc_write = ~load_use | branch_taken | (state == FLUSH). The redirect must not be frozen.
  - ifid_write = same expression as pc_write.
  - ifid_flush = branch_taken | (state == FLUSH).
  - A load_use that coincides with a flush is not counted as a stall.
- Load-use stall length is exactly one cycle: the injected bubble clears ex_readdmem on the next cycle.
- flush_active = registered (next state == FLUSH).
- Counters: stall_events increments on cycles with load_use & ~branch_taken & (state != FLUSH). flush_events increments on each branch_taken cycle. Both saturate at all-ones and never wrap.
- With branch_taken held high continuously, bubbles are injected every cycle, the state stays in FLUSH, and the counter never reaches 1.

Decomposition:
- Shared package holds:
  - control-bundle field offsets (ALUSRC, ALUFUNC[3:0], REGDEST, READDMEM, WRITEDMEM, REGWRITE, MEMTOREG);
  - the CTRL_W constant;
  - the NOP_CTRL all-zero constant;
  - the state enum {IDLE, FLUSH}.
- One natural sub-module, sat_counter (parameter W; inputs clk, rst, inc; output count), instantiated twice for the performance counters.

Test Plan:
- Reset: assert rst for 2 cycles while id_ctrl=10'h3FF -> ex_ctrl=0 and both counters 0; one cycle after release, ex_ctrl=10'h3FF.
- Pass-through: id_ctrl sequence 10'h001, 10'h155, 10'h2AA with no hazards -> the same values appear on ex_ctrl one cycle later; pc_write=ifid_write=1.
- Load-use: ex_readdmem=1, ex_rd=5, id_rs=5 -> pc_write=ifid_write=0 that cycle; next ex_ctrl=0; stall_events=1. Repeat with ex_rd=0 -> no stall. Repeat with id_rt=5 and id_uses_rt=0 -> no stall.
- Flush with FLUSH_CYCLES=3: one-cycle branch_taken pulse -> exactly 3 consecutive ex_ctrl=0; ifid_flush high 3 cycles; flush_active high 2 cycles; flush_events=1.
- Re-branch and priority: branch_taken during FLUSH, coincident with load_use -> flush restarts, pc_write=1, and stall_events is unchanged.
- Saturation: CNT_W=4 with 20 stall events -> stall_events stays at 4'hF.
